// File: rtl/or1200_mt_genpc_pkg.sv
// Shared definitions for the multithreaded OR1200 fetch PC generator:
// branch operation codes, field widths and default thread geometry.
package or1200_mt_genpc_pkg;

  localparam int BRANCHOP_WIDTH = 3;
  localparam int EXCEPT_WIDTH   = 4;
  localparam int DEF_NTHREADS   = 8;
  localparam int DEF_TW         = 3;

  typedef enum logic [BRANCHOP_WIDTH-1:0] {
    BRANCHOP_NOP = 3'd0,
    BRANCHOP_J   = 3'd1,
    BRANCHOP_JR  = 3'd2,
    BRANCHOP_BAL = 3'd3,
    BRANCHOP_BF  = 3'd4,
    BRANCHOP_BNF = 3'd5,
    BRANCHOP_RFE = 3'd6
  } branchop_e;

endpackage

// File: rtl/or1200_mt_rrarb.sv
// Round-robin arbiter: grants the first requesting index strictly after
// the last grant, wrapping modulo N.
module or1200_mt_rrarb #(
  parameter int N  = 8,
  parameter int TW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] last,
  output logic [TW-1:0] grant,
  output logic          valid
);

  int idx;

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    grant = last;
    valid = 1'b0;
    idx   = 0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last) + off) % N;
      if (req[idx]) begin
        grant = TW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/or1200_mt_genpc.sv
// Multithreaded PC generator: one PC per hardware thread, round-robin issue
// onto the instruction bus, and per-thread branch/exception/SPR/refetch redirects.
module or1200_mt_genpc
  import or1200_mt_genpc_pkg::*;
#(
  parameter int            NTHREADS = DEF_NTHREADS,
  parameter int            TW       = DEF_TW,
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = 'h100,
  parameter logic [AW-1:0] EXC_BASE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NTHREADS-1:0]       thread_en,
  output logic [AW-1:0]             icpu_adr_o,
  output logic                      icpu_cycstb_o,
  output logic [3:0]                icpu_sel_o,
  output logic [3:0]                icpu_tag_o,
  output logic [TW-1:0]             thread_out,
  input  logic                      icpu_rty_i,
  input  logic                      genpc_freeze,
  input  logic [BRANCHOP_WIDTH-1:0] branch_op,
  input  logic [TW-1:0]             branch_thread,
  input  logic [AW-3:0]             branch_addrofs,
  input  logic [AW-3:0]             binsn_addr,
  input  logic [AW-1:0]             lr_restor,
  input  logic                      flag,
  output logic                      taken,
  input  logic                      except_start,
  input  logic [TW-1:0]             except_thread,
  input  logic [EXCEPT_WIDTH-1:0]   except_type,
  input  logic [AW-1:0]             epcr,
  input  logic                      spr_pc_we,
  input  logic [TW-1:0]             wb_thread,
  input  logic [AW-1:0]             spr_dat_i,
  input  logic                      genpc_refetch,
  input  logic [TW-1:0]             refetch_thread
);

  localparam int PW = AW - 2;

  logic [PW-1:0] pc_rd [NTHREADS];
  logic [TW-1:0] rr_reg;
  logic [TW-1:0] grant;
  logic          grant_valid;
  logic          advance;
  logic [AW-1:0] adr_reg;
  logic          cycstb_reg;
  logic [TW-1:0] thread_reg;
  logic [PW-1:0] br_target;
  logic [AW-1:0] exc_vec;
  logic          unused_low_bits;

  assign advance = ~genpc_freeze & ~icpu_rty_i;
  assign exc_vec = EXC_BASE | AW'({except_type, 8'h00});
  assign unused_low_bits = ^{lr_restor[1:0], epcr[1:0], spr_dat_i[1:0], exc_vec[1:0]};

  always_comb begin
    taken     = 1'b0;
    br_target = binsn_addr + branch_addrofs;
    case (branch_op)
      BRANCHOP_J, BRANCHOP_BAL: taken = 1'b1;
      BRANCHOP_BF:  taken = flag;
      BRANCHOP_BNF: taken = ~flag;
      BRANCHOP_JR: begin
        taken     = 1'b1;
        br_target = lr_restor[AW-1:2];
      end
      BRANCHOP_RFE: begin
        taken     = 1'b1;
        br_target = epcr[AW-1:2];
      end
      default: taken = 1'b0;
    endcase
  end

  or1200_mt_rrarb #(.N(NTHREADS), .TW(TW)) u_rrarb (
    .req   (thread_en),
    .last  (rr_reg),
    .grant (grant),
    .valid (grant_valid)
  );

  for (genvar gi = 0; gi < NTHREADS; gi++) begin : g_thread
    logic [PW-1:0] pc_reg;
    logic [PW-1:0] pc_next;
    logic [PW-1:0] last_adr_reg;
    logic          issue;

    assign issue     = advance & grant_valid & (grant == TW'(gi));
    assign pc_rd[gi] = pc_reg;

    // A redirect overrides the post-issue increment; the issue itself still
    // used the old pc. Redirects are still accepted while the bus retries.
    always_comb begin
      pc_next = issue ? pc_reg + PW'(1) : pc_reg;
      if (!genpc_freeze) begin
        if (except_start && except_thread == TW'(gi))
          pc_next = exc_vec[AW-1:2];
        else if (spr_pc_we && wb_thread == TW'(gi))
          pc_next = spr_dat_i[AW-1:2];
        else if (taken && branch_thread == TW'(gi))
          pc_next = br_target;
        else if (genpc_refetch && refetch_thread == TW'(gi))
          pc_next = last_adr_reg;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pc_reg       <= RESET_PC[AW-1:2];
        last_adr_reg <= RESET_PC[AW-1:2];
      end else begin
        pc_reg <= pc_next;
        if (issue)
          last_adr_reg <= pc_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_reg    <= RESET_PC;
      cycstb_reg <= 1'b0;
      thread_reg <= '0;
      rr_reg     <= '0;
    end else if (advance) begin
      cycstb_reg <= grant_valid;
      if (grant_valid) begin
        adr_reg    <= {pc_rd[grant], 2'b00};
        thread_reg <= grant;
        rr_reg     <= grant;
      end
    end
  end

  assign icpu_adr_o    = adr_reg;
  assign icpu_cycstb_o = cycstb_reg;
  assign icpu_sel_o    = 4'hF;
  assign icpu_tag_o    = 4'(thread_reg);
  assign thread_out    = thread_reg;

endmodule

// File: doc/or1200_mt_genpc.md
Name: or1200_mt_genpc

Overview:
Parametrised multithreaded PC generator for the OR1200 fetch front-end. It holds one PC per hardware thread and picks a thread each cycle with a round-robin scheduler. It issues the selected fetch address and tag on the instruction CPU bus. Branch, exception and SPR PC-write redirects are applied per thread, and per-thread refetch and thread enable are supported, which the single-pointer genpc lacks.

Parameters:
NTHREADS, 8, number of hardware threads (2..16)
TW, 3, thread id width, equals clog2(NTHREADS)
AW, 32, address width; PCs are stored as [AW-1:2]
RESET_PC, 32'h0000_0100, PC loaded into every thread at reset
EXC_BASE, 32'h0000_0000, exception vector base; vector = EXC_BASE | {except_type,8'h00}

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
thread_en  in  NTHREADS  per-thread fetch enable mask
icpu_adr_o  out  AW  fetch address
icpu_cycstb_o  out  1  fetch request strobe
icpu_sel_o  out  4  byte select, constant 4'hF
icpu_tag_o  out  4  fetch tag, {1'b0, thread id} zero-extended
thread_out  out  TW  thread id of current fetch
icpu_rty_i  in  1  retry; hold current fetch
genpc_freeze  in  1  pipeline freeze; hold everything
branch_op  in  3  OR1200_BRANCHOP_* encoding
branch_thread  in  TW  thread owning branch_op
branch_addrofs  in  AW-2  branch word offset
binsn_addr  in  AW-2  branch instruction word address
lr_restor  in  AW  JR/JALR register target
flag  in  1  condition flag for BF/BNF
taken  out  1  branch taken indication
except_start  in  1  exception redirect strobe
except_thread  in  TW  thread taking the exception
except_type  in  4  exception code
epcr  in  AW  RFE return address
spr_pc_we  in  1  SPR write to PC
wb_thread  in  TW  thread targeted by spr_pc_we
spr_dat_i  in  AW  SPR write data
genpc_refetch  in  1  re-issue last address of refetch_thread
refetch_thread  in  TW  thread to refetch

Behaviour:
- Reset (rst=0, async): all pc[t]=RESET_PC, all last_adr[t]=RESET_PC, rr pointer=0, icpu_cycstb_o=0, icpu_adr_o=RESET_PC, thread_out=0, icpu_tag_o=0. Outputs are registered.
- Scheduler: each cycle with freeze=0 and rty=0, select the first enabled thread at or after rr+1, wrapping modulo NTHREADS. Register icpu_adr_o=pc[sel], thread_out=sel and cycstb=1. Then set last_adr[sel]=pc[sel], pc[sel]+=4 (word +1, wraps at 2^AW), rr=sel.
- No thread enabled: cycstb=0 next cycle; pc and rr unchanged.
- rty=1 or freeze=1: all outputs, pc[] and rr hold. Freeze has priority over redirects; redirect strobes arriving during freeze are ignored.
- Branch target by branch_op:
  - J/BAL: (binsn_addr+branch_addrofs)<<2
  - BF: same target if flag=1
  - BNF: same target if flag=0
  - JR: lr_restor with bits [1:0] forced to 0
  - RFE: epcr
  - NOP: no redirect
- taken: combinational. High for J, BAL, JR, RFE, BF&flag, BNF&~flag; low otherwise.
- Redirect priority per thread: except_start > spr_pc_we > taken branch > genpc_refetch (pc[t]=last_adr[t]) > sequential increment.
- Redirects to different threads in the same cycle all apply, each to its own thread.
- Same-cycle redirect and issue on the same thread: the issue still uses the old pc; the redirect value overwrites the +4.
- A redirect written in cycle N is used by that thread's next issue, at N+1 at the earliest.
- thread_en deasserted mid-run: the thread keeps its pc and may still accept redirects. Its in-flight fetch is not cancelled.
- rst asserted mid-fetch: immediate return to the reset state; cycstb drops asynchronously.

Decomposition:
- Shared package/defines (or1200_defines): OR1200_BRANCHOP_* codes, OR1200_BRANCHOP_WIDTH, OR1200_EXCEPT_WIDTH, default thread count and TW.
- One sub-module, or1200_mt_rrarb: parametrised round-robin arbiter (request mask, last grant in; grant index and valid out).
- PC array, redirect muxing and output registers stay in the top.

Test Plan:
- Reset release, all 8 threads enabled, no redirects -> thread_out cycles 1,2,..,7,0,1; each thread's address starts at 0x100 and steps +4 on its next grant.
- thread_en=8'b0010_0100 -> grants alternate threads 2 and 5 only. thread_en=0 -> cycstb=0 and addresses frozen.
- branch_op=J, branch_thread=5, binsn_addr=3, branch_addrofs=6 -> taken=1; thread 5's next fetch address 0x24.
- Same cycle: JR thread 3 with lr_restor=0xF0F0F0F3, and except_start thread 3 with except_type=4'h5 -> thread 3 fetches 0x500 (exception wins).
- icpu_rty_i held for 3 cycles during thread 2 fetch -> icpu_adr_o and thread_out stable, no pc advance. After release, thread 3 is granted next.
- genpc_refetch for thread 1 right after it fetched 0x108 -> thread 1's next fetch is again 0x108. Separately, spr_pc_we to wb_thread=2 with 0x2000 -> thread 2's next fetch 0x2000.
